// File: rtl/fpu_pkg.sv
// fpu_pkg: constants shared by the FP32 multiplier and its issue controller.
//   FP_W    : floating-point word width
//   FP_QNAN : canonical quiet NaN
//   cnt_w() : width of a counter that must hold 0..depth inclusive
package fpu_pkg;
    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: synchronous in-order result FIFO with clear.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : empty the FIFO this cycle (wins over push/pop)
//   i_push     : write i_data at the tail
//   i_pop      : remove the head (ignored when empty)
//   o_valid    : head holds data
//   o_head     : head data, 0 when empty
//   o_count    : number of stored entries
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = FP_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    // Overflow guard is belt-and-braces; the credit scheme upstream never
    // pushes into a full FIFO.
    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wptr] <= i_data;
    end

    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/fpu_mult_issue_ctrl.sv
// fpu_mult_issue_ctrl: credit-based issue and result buffering around the
// stall-free 3-stage FP32 multiplier.
//   clk, rst_n               : clock, async active-low reset (shared with multiplier)
//   in_valid/in_ready/in_a/b : operand handshake from the CPU side
//   flush                    : discard every queued and in-flight result
//   mult_valid_in/a/b        : issue port into the multiplier
//   mult_valid_out/result    : multiplier return port
//   out_valid/ready/result   : in-order result handshake to the consumer
//   occupancy                : FIFO entry count
//   busy                     : work in flight or queued
//   err                      : sticky, set by a return with nothing in flight
module fpu_mult_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FP_W-1:0]        in_a,
    input  logic [FP_W-1:0]        in_b,
    input  logic                   flush,
    output logic                   mult_valid_in,
    output logic [FP_W-1:0]        mult_a,
    output logic [FP_W-1:0]        mult_b,
    input  logic                   mult_valid_out,
    input  logic [FP_W-1:0]        mult_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP_W-1:0]        out_result,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   busy,
    output logic                   err
);
    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0] r_inflight, r_drop_cnt;
    logic          r_err;
    logic [CW:0]   w_credit_used;
    logic          w_issue, w_ret, w_spur, w_push, w_pop;

    // Every issued op owns a FIFO slot from issue until it is popped, so the
    // multiplier can never return into a full FIFO. Deliberately no path
    // from out_ready.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, occupancy};
    assign in_ready      = !flush && (w_credit_used < (CW+1)'(DEPTH));
    assign w_issue       = in_valid && in_ready;

    assign mult_valid_in = w_issue;
    assign mult_a        = in_a;
    assign mult_b        = in_b;

    // A return with nothing in flight is a protocol error: flag it and
    // ignore it so the counters cannot underflow.
    assign w_ret  = mult_valid_out && (r_inflight != '0);
    assign w_spur = mult_valid_out && (r_inflight == '0);

    // Returns are discarded while owed to an earlier flush, and in a flush
    // cycle itself.
    assign w_push = w_ret && (r_drop_cnt == '0) && !flush;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_ret);
            // Everything still in flight after this cycle predates the flush.
            if (flush)
                r_drop_cnt <= r_inflight - CW'(w_ret);
            else if (w_ret && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - 1'b1;
            if (w_spur) r_err <= 1'b1;
        end
    end

    fpu_result_fifo #(.DEPTH(DEPTH), .W(FP_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_data  (mult_result),
        .i_pop   (w_pop),
        .o_valid (out_valid),
        .o_head  (out_result),
        .o_count (occupancy)
    );

    assign busy = (r_inflight != '0) || (occupancy != '0);
    assign err  = r_err;
endmodule

// File: tb/tb_fpu_mult_issue_ctrl.sv
// Directed bench for fpu_mult_issue_ctrl with a 3-stage multiplier stand-in.
module tb_fpu_mult_issue_ctrl;
    import fpu_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, flush, mult_valid_in, mult_valid_out;
    logic [31:0]   in_a, in_b, mult_a, mult_b, mult_result, out_result;
    logic          out_valid, out_ready, busy, err, spur;
    logic [CW-1:0] occupancy;

    fpu_mult_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .flush(flush),
        .mult_valid_in(mult_valid_in), .mult_a(mult_a), .mult_b(mult_b),
        .mult_valid_out(mult_valid_out), .mult_result(mult_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .occupancy(occupancy), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Hand-computed products for the only operand pairs used here.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h3F80_0000) return a;                                  // x * 1.0
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000; // 2*3=6
        if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return 32'h4010_0000; // 1.5^2=2.25
        return FP_QNAN;
    endfunction

    // Multiplier stand-in: valid_in in cycle t -> valid_out in cycle t+3.
    logic [2:0]  m_v;
    logic [31:0] m_a1, m_a2, m_a3, m_b1, m_b2, m_b3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_v <= '0;
        else begin
            m_v  <= {m_v[1:0], mult_valid_in};
            m_a1 <= mult_a; m_a2 <= m_a1; m_a3 <= m_a2;
            m_b1 <= mult_b; m_b2 <= m_b1; m_b3 <= m_b2;
        end
    end
    assign mult_valid_out = m_v[2] | spur;
    assign mult_result    = spur ? 32'hDEAD_BEEF : fmul(m_a3, m_b3);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl [10] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                              32'h4110_0000, 32'h4120_0000};

    initial begin
        int acc;
        in_valid = 0; in_a = '0; in_b = '0; flush = 0; out_ready = 0; spur = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst mult_valid_in", mult_valid_in, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_result", out_result, 0);
        chk("rst occupancy", occupancy, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        nxt();
        rst_n = 1;
        nxt();

        // single op: 2.0 * 3.0
        for (int c = 0; c <= 5; c++) begin
            in_valid = (c == 0); in_a = 32'h4000_0000; in_b = 32'h4040_0000;
            out_ready = (c >= 4);
            @(negedge clk);
            if (c == 0) begin
                chk("single in_ready", in_ready, 1);
                chk("single issue", mult_valid_in, 1);
            end
            if (c >= 1 && c <= 3) begin
                chk($sformatf("single early c%0d", c), out_valid, 0);
                chk($sformatf("single busy c%0d", c), busy, 1);
            end
            if (c == 4) begin
                chk("single out_valid", out_valid, 1);
                chk("single result", out_result, 32'h40C0_0000);
            end
            if (c == 5) begin
                chk("single busy after pop", busy, 0);
                chk("single drained", out_valid, 0);
            end
            nxt();
        end

        // streaming: 10 back-to-back ops
        for (int c = 0; c <= 14; c++) begin
            in_valid = (c < 10); in_a = tbl[c % 10]; in_b = 32'h3F80_0000;
            out_ready = 1;
            @(negedge clk);
            if (c < 10) chk($sformatf("stream in_ready c%0d", c), in_ready, 1);
            if (c >= 4 && c <= 13) begin
                chk($sformatf("stream valid c%0d", c), out_valid, 1);
                chk($sformatf("stream res c%0d", c), out_result, tbl[c-4]);
            end
            if (c == 14) chk("stream idle", busy, 0);
            nxt();
        end

        // backpressure: 12 offered, 8 accepted, then drain
        acc = 0;
        for (int c = 0; c <= 20; c++) begin
            in_valid = (c < 12); in_a = tbl[c % 10]; in_b = 32'h3F80_0000;
            out_ready = (c >= 12);
            @(negedge clk);
            if (mult_valid_in) acc++;
            if (c < 12) chk($sformatf("bp in_ready c%0d", c), in_ready, (c < 8));
            if (c == 12) begin
                chk("bp accepted", acc, 8);
                chk("bp occupancy", occupancy, 8);
            end
            if (c == 13) chk("bp in_ready back", in_ready, 1);
            if (c >= 12 && c <= 19) begin
                chk($sformatf("bp valid c%0d", c), out_valid, 1);
                chk($sformatf("bp res c%0d", c), out_result, tbl[c-12]);
            end
            if (c == 20) begin
                chk("bp drained", out_valid, 0);
                chk("bp idle", busy, 0);
            end
            nxt();
        end

        // flush with 2 in flight and 1 queued, then 1.5*1.5
        for (int c = 0; c <= 10; c++) begin
            in_valid = (c == 0 || c == 2 || c == 3 || c == 4 || c == 5);
            in_a = (c == 0) ? 32'h4080_0000 : (c == 2) ? 32'h40A0_0000 :
                   (c == 3) ? 32'h40C0_0000 : (c == 4) ? 32'h4100_0000 : 32'h3FC0_0000;
            in_b = (c == 5) ? 32'h3FC0_0000 : 32'h3F80_0000;
            flush = (c == 4);
            out_ready = (c >= 4);
            @(negedge clk);
            if (c == 4) begin
                chk("fl occupancy pre", occupancy, 1);
                chk("fl in_ready", in_ready, 0);
                chk("fl no issue", mult_valid_in, 0);
            end
            if (c == 5) begin
                chk("fl occupancy post", occupancy, 0);
                chk("fl drop_cnt", dut.r_drop_cnt, 2);
                chk("fl in_ready post", in_ready, 1);
            end
            if (c >= 5 && c <= 8) chk($sformatf("fl quiet c%0d", c), out_valid, 0);
            if (c == 9) begin
                chk("fl valid", out_valid, 1);
                chk("fl result", out_result, 32'h4010_0000);
            end
            if (c == 10) chk("fl idle", busy, 0);
            nxt();
        end
        flush = 0;

        // flush coincident with a return and a pop
        for (int c = 0; c <= 7; c++) begin
            in_valid = (c <= 2); in_a = tbl[6 + (c % 3)]; in_b = 32'h3F80_0000;
            flush = (c == 4);
            out_ready = (c >= 4);
            @(negedge clk);
            if (c == 4) begin
                chk("flc return", mult_valid_out, 1);
                chk("flc head", out_valid, 1);
            end
            if (c == 5) begin
                chk("flc occupancy", occupancy, 0);
                chk("flc drop_cnt", dut.r_drop_cnt, 1);
                chk("flc inflight", dut.r_inflight, 1);
            end
            if (c >= 5) chk($sformatf("flc quiet c%0d", c), out_valid, 0);
            if (c == 6) begin
                chk("flc drop done", dut.r_drop_cnt, 0);
                chk("flc idle", busy, 0);
            end
            nxt();
        end
        flush = 0;

        // spurious return with nothing in flight
        for (int c = 0; c <= 3; c++) begin
            in_valid = 0; out_ready = 1;
            spur = (c == 0);
            @(negedge clk);
            if (c >= 1) begin
                chk($sformatf("spur err c%0d", c), err, 1);
                chk($sformatf("spur quiet c%0d", c), out_valid, 0);
                chk($sformatf("spur occ c%0d", c), occupancy, 0);
            end
            if (c == 1) chk("spur inflight", dut.r_inflight, 0);
            nxt();
        end
        spur = 0;

        // reset mid-stream
        for (int c = 0; c <= 3; c++) begin
            in_valid = 1; in_a = tbl[c]; in_b = 32'h3F80_0000; out_ready = 0;
            @(negedge clk);
            if (c == 3) begin
                chk("mid busy", busy, 1);
                rst_n = 0;
                in_valid = 0;
                #1;
                chk("mr in_ready", in_ready, 1);
                chk("mr mult_valid_in", mult_valid_in, 0);
                chk("mr out_valid", out_valid, 0);
                chk("mr out_result", out_result, 0);
                chk("mr occupancy", occupancy, 0);
                chk("mr busy", busy, 0);
                chk("mr err", err, 0);
            end
            nxt();
        end
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst quiet c%0d", c), out_valid, 0);
            chk($sformatf("post-rst busy c%0d", c), busy, 0);
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_mult_issue_ctrl.md
# fpu_mult_issue_ctrl

Issue and result-buffer controller that sits directly upstream of the 3-stage FP32 multiplier, `fpu_mult_pipelined`, and also captures that multiplier's output. The multiplier pipeline has no stall input, so this block admits an operation only when a result slot is already guaranteed (credit scheme). It queues results in order and presents them on a ready/valid interface to the CPU-side consumer. It also supports a synchronous flush that discards in-flight and queued results.

## Interface
Parameters:
- `DEPTH`, 8: result FIFO entries. Must be a power of two, ≥2. Full throughput requires ≥5.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: operand pair accepted when `in_valid & in_ready`.
- `in_a`, `in_b` in 32: FP32 operands.
- `flush` in 1: synchronous discard of all queued and in-flight results.
- `mult_valid_in` out 1: drives the multiplier's `valid_in`.
- `mult_a`, `mult_b` out 32: drive the multiplier's `a` and `b`.
- `mult_valid_out` in 1: the multiplier's `valid_out`.
- `mult_result` in 32: the multiplier's `result`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer takes the head when `out_valid & out_ready`.
- `out_result` out 32: FIFO head; 0 when `out_valid`=0.
- `occupancy` out $clog2(DEPTH)+1: FIFO entry count.
- `busy` out 1: inflight≠0 or occupancy≠0.
- `err` out 1: sticky protocol error.

## Operation
Registered state:
- `inflight`: ops issued but not yet returned.
- `drop_cnt`: returning results still to be discarded.
- The FIFO.
- `err`.

Issue path:
- `in_ready = !flush && (inflight + occupancy) < DEPTH`. It is computed from registers and `flush` only; there is no path from `out_ready`.
- `mult_valid_in = in_valid & in_ready`. `mult_a = in_a` and `mult_b = in_b` pass through combinationally.
- Each issue increments `inflight`.

Return path, on each `mult_valid_out`:
- `inflight` decrements.
- If `drop_cnt`≠0: decrement `drop_cnt` and discard the result.
- Otherwise: push `mult_result` into the FIFO. The credit rule guarantees the FIFO is never full here.

Pop:
- On `out_valid & out_ready`, the head is removed.
- Push and pop in the same cycle leave `occupancy` unchanged.

Flush, in any cycle it is high:
- Nothing is issued.
- The FIFO is emptied; a pop that cycle is ignored.
- `drop_cnt <= inflight - mult_valid_out`. A result arriving in the flush cycle is itself discarded.
- `inflight` still updates normally.
- Operations issued after the flush return after the dropped ones, because ordering is preserved, and are kept.

Error:
- `mult_valid_out` while `inflight`=0 sets `err`. That result is discarded and counters do not underflow.
- `err` is cleared only by reset.

Arithmetic: all counters are $clog2(DEPTH)+1 bits. The sum `inflight + occupancy` is evaluated at that width plus one, with no wrap.

## Timing
- Reset values: `in_ready`=1, `mult_valid_in`=0, `out_valid`=0, `out_result`=0, `occupancy`=0, `busy`=0, `err`=0. `inflight`, `drop_cnt` and the FIFO pointers are all 0.
- Latency: accepted in cycle t → multiplier `valid_out` in t+3 → FIFO write at the end of t+3 → `out_valid` in t+4.
- Credit hold: a credit is held from cycle t until the cycle after the pop, i.e. 5 cycles with `out_ready`=1. DEPTH=4 therefore sustains 4 ops per 5 cycles; DEPTH≥5 sustains 1 op per cycle.
- Reset mid-operation: all state clears immediately. The multiplier shares `rst_n`, so no stale result returns.

## Structure
- Shared package `fpu_pkg`: `FP_W=32` and `FP_QNAN=32'h7FC00000`, shared with the multiplier.
- Sub-module `fpu_result_fifo`: synchronous FIFO with clear, push, pop, count and head outputs.
- Credit, drop and error logic live in the top module.

## Test plan
- Single op: `0x40000000`×`0x40400000` accepted at cycle 0 → `out_valid`=1 at cycle 4 with `out_result`=`0x40C00000`; `busy` returns to 0 one cycle after the pop.
- Streaming: 10 back-to-back ops, `out_ready`=1, DEPTH=8 → `in_ready` never drops; results appear in order on cycles 4–13.
- Backpressure: `out_ready`=0, 12 ops offered → exactly 8 accepted; `in_ready`=0 from cycle 8; `occupancy` reaches 8. Raising `out_ready` drains all 8 in order, and `in_ready` returns.
- Flush with 2 in flight and 1 queued → nothing from those 3 ever appears on the output. A subsequent `0x3FC00000`×`0x3FC00000` returns `0x40100000` as the first output.
- Flush coincident with `mult_valid_out` and an `out_ready` pop → that result is dropped, the FIFO is empty next cycle, and `drop_cnt` equals the remaining inflight count.
- Spurious `mult_valid_out` with `inflight`=0 → `err`=1 stays set; `out_valid` stays 0. Asserting `rst_n` low mid-stream clears all outputs to their reset values.
